// File: rtl/bios_block_sink_pkg.sv
// Shared types for the BIOS block sink: FSM state encoding
// and the default burst length.
package bios_block_sink_pkg;

   localparam int BLOCK_WORDS_DEF = 32;

   typedef enum logic [2:0] {
      IDLE,
      PULL,
      DRAIN,
      FLUSH,
      WAITLOW
   } state_t;

endpackage

// File: rtl/bios_block_sink_line_buf.sv
// Line buffer for one BIOS block: synchronous write port,
// asynchronous read port. Contents are never reset.
module bios_line_buf #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk_sys,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [15:0]   wd,
   input  logic [AW-1:0] ra,
   output logic [15:0]   rd
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk_sys) begin
      if (we) mem[wa] <= wd;
   end

   assign rd = mem[ra];

endmodule

// File: rtl/bios_block_sink.sv
// Pulls one BIOS block from the producer into a line buffer,
// then flushes it word by word to memory with an ack handshake.
module bios_block_sink
   import bios_block_sink_pkg::*;
#(
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
   parameter int ADDR_W      = 16,
   parameter int BASE_ADDR   = 0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              dl_active,
   input  logic              bios_wr,
   input  logic [15:0]       bios_din,
   output logic              bios_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_dout,
   output logic              mem_wr,
   input  logic              mem_ack,
   output logic              busy,
   output logic              block_done
);

   localparam int IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(BLOCK_WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   state_t state, state_n;

   logic [IW-1:0] idx;
   logic [IW-1:0] idx_d;
   logic [IW-1:0] rd_idx;
   logic [15:0]   rd_data;
   logic          req_d;
   logic          dl_q;
   logic          pend;
   logic          rise;
   logic          accept;
   logic          last;
   logic          enter_idle;

   assign rise       = dl_active & ~dl_q;
   assign accept     = (state == FLUSH) & mem_ack;
   assign last       = (idx == LAST);
   assign enter_idle = (state != IDLE) & (state_n == IDLE);

   assign bios_req = (state == PULL);
   assign mem_wr   = (state == FLUSH);
   assign busy     = (state != IDLE);

   // Look one word ahead on accept so mem_dout is ready next cycle
   assign rd_idx = accept ? idx + IW'(1) : idx;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (bios_wr)         state_n = PULL;
         PULL:    if (last)            state_n = DRAIN;
         DRAIN:                        state_n = FLUSH;
         FLUSH:   if (accept && last)  state_n = WAITLOW;
         WAITLOW: if (!bios_wr)        state_n = IDLE;
         default:                      state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         idx        <= '0;
         idx_d      <= '0;
         req_d      <= 1'b0;
         dl_q       <= 1'b0;
         pend       <= 1'b0;
         mem_addr   <= BASE;
         mem_dout   <= '0;
         block_done <= 1'b0;
      end else begin
         dl_q       <= dl_active;
         req_d      <= bios_req;
         idx_d      <= idx;
         block_done <= accept & last;
         if ((state == PULL) || accept)
            idx <= last ? '0 : idx + IW'(1);
         if ((state == DRAIN) || (accept && !last))
            mem_dout <= rd_data;
         if (accept)
            mem_addr <= mem_addr + ADDR_W'(1);
         // A restart seen while busy is held until we are back in IDLE
         if (((state == IDLE) && rise) || (enter_idle && (pend || rise))) begin
            mem_addr <= BASE;
            pend     <= 1'b0;
         end else if (rise && (state != IDLE)) begin
            pend <= 1'b1;
         end
      end
   end

   bios_line_buf #(
      .DEPTH (BLOCK_WORDS),
      .AW    (IW)
   ) u_buf (
      .clk_sys (clk_sys),
      .we      (req_d),
      .wa      (idx_d),
      .wd      (bios_din),
      .ra      (rd_idx),
      .rd      (rd_data)
   );

endmodule

// File: tb/tb_bios_block_sink.sv
// Directed bench for bios_block_sink: one 16-bit-address instance
// and one 6-bit-address instance driven by the same stimulus.
module tb_bios_block_sink;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        dl_active;
   logic        bios_wr;
   logic [15:0] bios_din;
   logic        bios_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_dout;
   logic        mem_wr;
   logic        mem_ack;
   logic        busy;
   logic        block_done;

   logic        w6_req;
   logic [5:0]  w6_addr;
   logic [15:0] w6_dout;
   logic        w6_wr;
   logic        w6_busy;
   logic        w6_done;

   bios_block_sink u_dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .dl_active  (dl_active),
      .bios_wr    (bios_wr),
      .bios_din   (bios_din),
      .bios_req   (bios_req),
      .mem_addr   (mem_addr),
      .mem_dout   (mem_dout),
      .mem_wr     (mem_wr),
      .mem_ack    (mem_ack),
      .busy       (busy),
      .block_done (block_done)
   );

   bios_block_sink #(.ADDR_W(6)) u_w6 (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .dl_active  (dl_active),
      .bios_wr    (bios_wr),
      .bios_din   (bios_din),
      .bios_req   (w6_req),
      .mem_addr   (w6_addr),
      .mem_dout   (w6_dout),
      .mem_wr     (w6_wr),
      .mem_ack    (mem_ack),
      .busy       (w6_busy),
      .block_done (w6_done)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   logic [15:0] prod_base;
   int          prod_k;
   logic        prev_req;
   logic [15:0] exp_addr;
   logic [5:0]  exp_addr6;
   logic [15:0] exp_data;
   int          nreq, nacc, ndone;
   int          stall_at, stall_left;
   int          act_at_req, act_at_acc;
   logic        act_val;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: producer, ack driver and write checker
   task automatic cyc();
      @(posedge clk_sys);
      #1;
      if (prev_req) begin
         bios_din = prod_base + 16'(prod_k);
         prod_k++;
      end else begin
         bios_din = 16'hDEAD;
      end
      prev_req = bios_req;
      if (bios_req) nreq++;
      if (nreq == act_at_req) dl_active = act_val;
      if (nacc == act_at_acc && mem_wr) dl_active = act_val;
      if (block_done) begin
         ndone++;
         chk("done_wr_low", {31'd0, mem_wr}, 32'd0);
         chk("done_after_all", nacc, 32);
      end
      if (mem_wr) begin
         chk("wr_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
         chk("wr_data", {16'd0, mem_dout}, {16'd0, exp_data});
         chk("w6_addr", {26'd0, w6_addr}, {26'd0, exp_addr6});
         chk("w6_data", {16'd0, w6_dout}, {16'd0, exp_data});
         if (stall_at == nacc && stall_left > 0) begin
            mem_ack = 1'b0;
            stall_left--;
         end else begin
            mem_ack = 1'b1;
            nacc++;
            exp_addr++;
            exp_addr6++;
            exp_data++;
         end
      end else begin
         mem_ack = 1'b1;
      end
   endtask

   task automatic run_block(input logic [15:0] base);
      int n;
      prod_base = base;
      prod_k    = 0;
      nreq      = 0;
      nacc      = 0;
      ndone     = 0;
      exp_data  = base;
      bios_wr   = 1'b1;
      n = 0;
      while (ndone == 0 && n < 300) begin
         cyc();
         n++;
      end
      chk("blk_done", ndone, 1);
      chk("blk_reqs", nreq, 32);
      chk("blk_accepts", nacc, 32);
      cyc();
      cyc();
      chk("done_once", ndone, 1);
      chk("wait_hold", {31'd0, busy}, 32'd1);
      chk("no_repull", nreq, 32);
      bios_wr = 1'b0;
      cyc();
      cyc();
      chk("idle_after", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      dl_active  = 1'b0;
      bios_wr    = 1'b0;
      mem_ack    = 1'b0;
      bios_din   = 16'h0;
      prev_req   = 1'b0;
      prod_base  = 16'h0;
      prod_k     = 0;
      exp_addr   = 16'h0;
      exp_addr6  = 6'h0;
      exp_data   = 16'h0;
      nreq       = 0;
      nacc       = 0;
      ndone      = 0;
      stall_at   = -1;
      stall_left = 0;
      act_at_req = -1;
      act_at_acc = -1;
      act_val    = 1'b0;

      repeat (2) @(posedge clk_sys);
      #1;
      chk("rst_req", {31'd0, bios_req}, 32'd0);
      chk("rst_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, block_done}, 32'd0);
      chk("rst_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_dout", {16'd0, mem_dout}, 32'd0);
      chk("rst_w6_addr", {26'd0, w6_addr}, 32'd0);
      reset = 1'b0;
      cyc();

      // Block 1: download start, ack stalled 5 cycles on word 7
      dl_active  = 1'b1;
      stall_at   = 7;
      stall_left = 5;
      run_block(16'h1000);
      chk("stall_used", stall_left, 0);
      stall_at = -1;

      // Block 2: continues at 32, dl_active drops mid-pull
      act_at_req = 10;
      act_val    = 1'b0;
      run_block(16'h2000);
      act_at_req = -1;
      chk("b2_end_addr", {16'd0, mem_addr}, 32'd64);
      chk("b2_dl_low", {31'd0, dl_active}, 32'd0);

      // Block 3: 6-bit instance has wrapped to 0
      run_block(16'h3000);
      chk("b3_end_addr", {16'd0, mem_addr}, 32'd96);
      chk("b3_w6_end", {26'd0, w6_addr}, 32'd32);

      // Reset during the 10th pull cycle
      bios_wr = 1'b1;
      nreq = 0;
      n = 0;
      while (nreq < 10 && n < 50) begin
         cyc();
         n++;
      end
      chk("pull10", nreq, 10);
      reset = 1'b1;
      #1;
      chk("mid_rst_req", {31'd0, bios_req}, 32'd0);
      chk("mid_rst_wr", {31'd0, mem_wr}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_addr", {16'd0, mem_addr}, 32'd0);
      prev_req = 1'b0;
      bios_wr  = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();

      // Block 4: from BASE, dl_active re-rises during flush
      exp_addr   = 16'h0;
      exp_addr6  = 6'h0;
      act_at_acc = 5;
      act_val    = 1'b1;
      run_block(16'h4000);
      act_at_acc = -1;
      chk("pend_applied", {16'd0, mem_addr}, 32'd0);

      // Block 5: restarts at BASE
      exp_addr  = 16'h0;
      exp_addr6 = 6'h0;
      run_block(16'h5000);
      chk("b5_end_addr", {16'd0, mem_addr}, 32'd32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
